// File: rtl/sdbp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdbp_pkg
// Description : Shared types and default sizing for the SDBP frame transmitter
// Revision    : 1.0 - initial release
// ============================================================================
package sdbp_pkg;

    localparam int N_LED = 360;   // words per frame
    localparam int DW    = 16;    // LED word width
    localparam int AW    = 10;    // brightness RAM address width

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        FETCH = 3'd2,
        LOAD  = 3'd3,
        SHIFT = 3'd4,
        LATCH = 3'd5,
        DONE  = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sdbp_frame_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : sdbp_frame_tx_if
// Description : Brightness RAM read port (enable/address out, data back in
//               one cycle after the enable)
// Revision    : 1.0 - initial release
// ============================================================================
interface sdbp_frame_tx_if #(
    parameter int AW = 10,
    parameter int DW = 16
) ();

    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;

    modport master (output rd_en, output rd_addr, input  rd_data);
    modport slave  (input  rd_en, input  rd_addr, output rd_data);

endinterface
`default_nettype wire

// File: rtl/sdbp_shifter.sv
`default_nettype none
// ============================================================================
// Module      : sdbp_shifter
// Description : MSB-first word serialiser; sclk low for the first CLK_DIV
//               cycles of each bit, high for the rest; sdo changes only on
//               the first low cycle of a bit
// Revision    : 1.0 - initial release
// ============================================================================
module sdbp_shifter #(
    parameter int DW      = 16,
    parameter int CLK_DIV = 2
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          load,
    input  wire logic [DW-1:0] din,
    output logic               busy,
    output logic               last,
    output logic               sclk,
    output logic               sdo
);

    localparam int PW = $clog2(2 * CLK_DIV);
    localparam int BW = $clog2(DW);

    logic [DW-1:0] sr,      sr_nxt;
    logic [PW-1:0] phase,   phase_nxt;
    logic [BW-1:0] bit_cnt, bit_nxt;
    logic          active,  active_nxt;
    logic          bit_end;

    assign bit_end = active && (phase == PW'(2 * CLK_DIV - 1));
    assign last    = bit_end && (bit_cnt == BW'(DW - 1));
    assign busy    = active;

    // Next shift-register, phase and bit-count values
    always_comb begin
        sr_nxt     = sr;
        phase_nxt  = phase;
        bit_nxt    = bit_cnt;
        active_nxt = active;
        if (load) begin
            sr_nxt     = din;
            phase_nxt  = '0;
            bit_nxt    = '0;
            active_nxt = 1'b1;
        end else if (active) begin
            if (bit_end) begin
                phase_nxt = '0;
                sr_nxt    = {sr[DW-2:0], 1'b0};
                if (last) begin
                    active_nxt = 1'b0;
                end else begin
                    bit_nxt = bit_cnt + BW'(1);
                end
            end else begin
                phase_nxt = phase + PW'(1);
            end
        end
    end

    // State registers; sclk/sdo are registered so the driver sees clean edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr      <= '0;
            phase   <= '0;
            bit_cnt <= '0;
            active  <= 1'b0;
            sclk    <= 1'b0;
            sdo     <= 1'b0;
        end else begin
            sr      <= sr_nxt;
            phase   <= phase_nxt;
            bit_cnt <= bit_nxt;
            active  <= active_nxt;
            sclk    <= active_nxt && (phase_nxt >= PW'(CLK_DIV));
            sdo     <= active_nxt && sr_nxt[DW-1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdbp_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : sdbp_frame_tx
// Description : On each rising edge of frame_start, waits out the RAM write
//               burst, reads N_LED words from the brightness RAM, shifts them
//               to the MiniLED driver and pulses le to latch the frame
// Revision    : 1.0 - initial release
// ============================================================================
module sdbp_frame_tx #(
    parameter int N_LED     = sdbp_pkg::N_LED,
    parameter int DW        = sdbp_pkg::DW,
    parameter int AW        = sdbp_pkg::AW,
    parameter int BASE_ADDR = 1,
    parameter int START_DLY = 400,
    parameter int CLK_DIV   = 2,
    parameter int LATCH_W   = 4
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       frame_start,
    sdbp_frame_tx_if.master ram,
    output logic            sclk,
    output logic            sdo,
    output logic            le,
    output logic            busy,
    output logic            frame_done,
    output logic            overrun
);

    import sdbp_pkg::*;

    localparam int IW      = $clog2(N_LED);
    localparam int DLY_MAX = (START_DLY > LATCH_W) ? START_DLY : LATCH_W;
    localparam int CW      = $clog2(DLY_MAX + 1);

    state_t        state, state_nxt;
    logic [IW-1:0] word_idx, word_idx_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          armed, fs_q, start_edge;
    logic          sh_load, sh_busy, sh_last;

    // armed is low for the first cycle after reset so a level that is already
    // high when reset releases is absorbed into fs_q instead of seen as an edge
    assign start_edge = armed && frame_start && !fs_q;

    // frame_start history for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
            fs_q  <= 1'b0;
        end else begin
            armed <= 1'b1;
            fs_q  <= frame_start;
        end
    end

    // Next-state, word index and shared delay/latch counter
    always_comb begin
        state_nxt    = state;
        word_idx_nxt = word_idx;
        cnt_nxt      = cnt;
        sh_load      = 1'b0;
        case (state)
            IDLE: begin
                if (start_edge) begin
                    state_nxt    = WAIT;
                    cnt_nxt      = CW'(START_DLY - 1);
                    word_idx_nxt = '0;
                end
            end
            WAIT: begin
                if (cnt == '0) state_nxt = FETCH;
                else           cnt_nxt   = cnt - CW'(1);
            end
            FETCH: state_nxt = LOAD;
            LOAD: begin
                sh_load   = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                // An idle shifter here can only mean a lost word; moving on
                // keeps the FSM from locking up
                if (sh_last || !sh_busy) begin
                    if (word_idx == IW'(N_LED - 1)) begin
                        state_nxt = LATCH;
                        cnt_nxt   = CW'(LATCH_W - 1);
                    end else begin
                        word_idx_nxt = word_idx + IW'(1);
                        state_nxt    = FETCH;
                    end
                end
            end
            LATCH: begin
                if (cnt == '0) state_nxt = DONE;
                else           cnt_nxt   = cnt - CW'(1);
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM registers and registered outputs decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            word_idx    <= '0;
            cnt         <= '0;
            ram.rd_en   <= 1'b0;
            ram.rd_addr <= '0;
            le          <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state      <= state_nxt;
            word_idx   <= word_idx_nxt;
            cnt        <= cnt_nxt;
            ram.rd_en  <= (state_nxt == FETCH);
            if (state_nxt == FETCH) begin
                ram.rd_addr <= AW'(BASE_ADDR) + AW'(word_idx_nxt);
            end
            le         <= (state_nxt == LATCH);
            busy       <= (state_nxt != IDLE);
            frame_done <= (state_nxt == DONE);
            overrun    <= start_edge && (state != IDLE);
        end
    end

    sdbp_shifter #(
        .DW      (DW),
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (sh_load),
        .din   (ram.rd_data),
        .busy  (sh_busy),
        .last  (sh_last),
        .sclk  (sclk),
        .sdo   (sdo)
    );

endmodule
`default_nettype wire

// File: tb/tb_sdbp_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdbp_frame_tx
// Description : Self-checking bench for sdbp_frame_tx; instance A uses the
//               default sizing, instance B is a short frame with CLK_DIV=1
//               and a base address that wraps the 10-bit RAM space
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdbp_frame_tx;

    localparam int A_N = 360, A_DLY = 400, A_DIV = 2, A_LW = 4, A_BASE = 1;
    localparam int B_N = 8,   B_DLY = 20,  B_DIV = 1, B_LW = 4, B_BASE = 1020;
    localparam int A_LEN = A_DLY + A_N * (2 + 16 * 2 * A_DIV) + A_LW + 1;
    localparam int B_LEN = B_DLY + B_N * (2 + 16 * 2 * B_DIV) + B_LW + 1;

    logic clk = 1'b0, rst_n = 1'b0, fs_a = 1'b0, fs_b = 1'b0;
    always #5 clk = ~clk;

    sdbp_frame_tx_if #(.AW(10), .DW(16)) bus_a ();
    sdbp_frame_tx_if #(.AW(10), .DW(16)) bus_b ();
    logic sclk_a, sdo_a, le_a, busy_a, done_a, ovr_a;
    logic sclk_b, sdo_b, le_b, busy_b, done_b, ovr_b;

    sdbp_frame_tx #(.N_LED(A_N), .BASE_ADDR(A_BASE), .START_DLY(A_DLY),
                    .CLK_DIV(A_DIV), .LATCH_W(A_LW)) dut_a (
        .clk(clk), .rst_n(rst_n), .frame_start(fs_a), .ram(bus_a.master),
        .sclk(sclk_a), .sdo(sdo_a), .le(le_a), .busy(busy_a),
        .frame_done(done_a), .overrun(ovr_a));

    sdbp_frame_tx #(.N_LED(B_N), .BASE_ADDR(B_BASE), .START_DLY(B_DLY),
                    .CLK_DIV(B_DIV), .LATCH_W(B_LW)) dut_b (
        .clk(clk), .rst_n(rst_n), .frame_start(fs_b), .ram(bus_b.master),
        .sclk(sclk_b), .sdo(sdo_b), .le(le_b), .busy(busy_b),
        .frame_done(done_b), .overrun(ovr_b));

    // RAM models: data valid one cycle after rd_en
    logic [15:0] mem_a [0:1023];
    logic [15:0] mem_b [0:1023];
    always @(posedge clk) if (bus_a.rd_en) bus_a.rd_data <= mem_a[bus_a.rd_addr];
    always @(posedge clk) if (bus_b.rd_en) bus_b.rd_data <= mem_b[bus_b.rd_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor A: bits on sclk rise, read addresses, pulse/level counts
    logic bits_a[$];
    int   addr_a[$], rdcyc_a[$];
    int   le_cnt_a = 0, done_cnt_a = 0, ovr_cnt_a = 0, busy_cnt_a = 0, bad_a = 0;
    int   rise_cyc_a = 0, done_cyc_a = 0;
    logic sclk_pa = 1'b0, sdo_pa = 1'b0, busy_pa = 1'b0;
    always @(negedge clk) begin
        if (sclk_a && !sclk_pa) bits_a.push_back(sdo_a);
        if (bus_a.rd_en) begin
            addr_a.push_back(int'(bus_a.rd_addr));
            rdcyc_a.push_back(cyc);
        end
        if ((sclk_a && sclk_pa && sdo_a !== sdo_pa) || ((sclk_a || sdo_a) && (!busy_a || le_a)))
            bad_a <= bad_a + 1;
        if (le_a)   le_cnt_a   <= le_cnt_a + 1;
        if (done_a) begin done_cnt_a <= done_cnt_a + 1; done_cyc_a <= cyc; end
        if (ovr_a)  ovr_cnt_a  <= ovr_cnt_a + 1;
        if (busy_a) busy_cnt_a <= busy_cnt_a + 1;
        if (busy_a && !busy_pa) rise_cyc_a <= cyc;
        sclk_pa <= sclk_a; sdo_pa <= sdo_a; busy_pa <= busy_a;
    end

    // Monitor B: same, plus count of 2-cycle sclk periods
    logic bits_b[$];
    int   addr_b[$];
    int   le_cnt_b = 0, done_cnt_b = 0, ovr_cnt_b = 0, busy_cnt_b = 0, bad_b = 0;
    int   per2_b = 0, last_rise_b = 0;
    logic sclk_pb = 1'b0, sdo_pb = 1'b0;
    always @(negedge clk) begin
        if (sclk_b && !sclk_pb) begin
            bits_b.push_back(sdo_b);
            if (cyc - last_rise_b == 2) per2_b <= per2_b + 1;
            last_rise_b <= cyc;
        end
        if (bus_b.rd_en) addr_b.push_back(int'(bus_b.rd_addr));
        if ((sclk_b && sclk_pb && sdo_b !== sdo_pb) || ((sclk_b || sdo_b) && (!busy_b || le_b)))
            bad_b <= bad_b + 1;
        if (le_b)   le_cnt_b   <= le_cnt_b + 1;
        if (done_b) done_cnt_b <= done_cnt_b + 1;
        if (ovr_b)  ovr_cnt_b  <= ovr_cnt_b + 1;
        if (busy_b) busy_cnt_b <= busy_cnt_b + 1;
        sclk_pb <= sclk_b; sdo_pb <= sdo_b;
    end

    int n_checks = 0, n_pass = 0;
    int nb, na, d0, o0, b0, l0, g0, p0, errs;
    bit ok;

    // Reference: frame bit k is bit (15 - k%16) of RAM word (BASE + k/16) mod 1024
    function automatic logic exp_bit_a(int k);
        logic [15:0] w;
        w = mem_a[(A_BASE + k / 16) % 1024];
        return w[15 - k % 16];
    endfunction

    function automatic logic exp_bit_b(int k);
        logic [15:0] w;
        w = mem_b[(B_BASE + k / 16) % 1024];
        return w[15 - k % 16];
    endfunction

    task automatic snap_b();
        nb = bits_b.size(); na = addr_b.size(); d0 = done_cnt_b; o0 = ovr_cnt_b;
        b0 = busy_cnt_b; l0 = le_cnt_b; g0 = bad_b; p0 = per2_b;
    endtask

    task automatic fill_b();
        for (int i = 0; i < 1024; i++) mem_b[i] = 16'($urandom);
    endtask

    task automatic pulse_b();
        @(negedge clk) fs_b = 1'b1;
        @(negedge clk) fs_b = 1'b0;
    endtask

    task automatic wait_done_b(input int budget, output bit done);
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_b) begin done = 1'b1; break; end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic stream_errs_b();
        errs = 0;
        if (bits_b.size() < nb + B_N * 16) errs = -1;
        else for (int k = 0; k < B_N * 16; k++)
            if (bits_b[nb + k] !== exp_bit_b(k)) errs++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fs_a = 1'b0; fs_b = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if ({bus_a.rd_en, bus_a.rd_addr} !== 11'd0) $display("FAIL reset_a_rd: got %h want 0", {bus_a.rd_en, bus_a.rd_addr}); else n_pass++;
        n_checks++; if ({sclk_a, sdo_a, le_a, busy_a, done_a, ovr_a} !== 6'd0) $display("FAIL reset_a_out: got %b want 000000", {sclk_a, sdo_a, le_a, busy_a, done_a, ovr_a}); else n_pass++;
        n_checks++; if ({bus_b.rd_en, bus_b.rd_addr} !== 11'd0) $display("FAIL reset_b_rd: got %h want 0", {bus_b.rd_en, bus_b.rd_addr}); else n_pass++;
        n_checks++; if ({sclk_b, sdo_b, le_b, busy_b, done_b, ovr_b} !== 6'd0) $display("FAIL reset_b_out: got %b want 000000", {sclk_b, sdo_b, le_b, busy_b, done_b, ovr_b}); else n_pass++;
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++; if ({busy_a, busy_b} !== 2'b00) $display("FAIL reset_release_idle: busy=%b want 00", {busy_a, busy_b}); else n_pass++;
    endtask

    task automatic test_frame_default();
        int nra, dd0, bb0, ll0, gg0, oo0, e;
        logic [15:0] w0;
        for (int i = 0; i < 1024; i++) mem_a[i] = 16'(i * 256);
        nb = bits_a.size(); nra = addr_a.size(); dd0 = done_cnt_a; bb0 = busy_cnt_a;
        ll0 = le_cnt_a; gg0 = bad_a; oo0 = ovr_cnt_a;
        @(negedge clk) fs_a = 1'b1;
        repeat (3) @(negedge clk);
        fs_a = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < A_LEN + 200; i++) begin
            @(negedge clk);
            if (done_a) begin ok = 1'b1; break; end
        end
        repeat (5) @(negedge clk);
        n_checks++; if (ok !== 1'b1) $display("FAIL dflt_timeout: frame_done not seen within %0d cycles", A_LEN + 200); else n_pass++;
        n_checks++; if (addr_a.size() != nra + A_N) $display("FAIL dflt_nreads: got %0d want %0d", addr_a.size() - nra, A_N); else n_pass++;
        e = 0;
        for (int i = 0; i < A_N; i++) if (nra + i >= addr_a.size() || addr_a[nra + i] != A_BASE + i) e++;
        n_checks++; if (e != 0) $display("FAIL dflt_addr_order: %0d wrong addresses want 0", e); else n_pass++;
        n_checks++; if (rdcyc_a.size() <= nra || rdcyc_a[nra] - rise_cyc_a != A_DLY) $display("FAIL dflt_start_dly: got %0d want %0d", (rdcyc_a.size() > nra) ? rdcyc_a[nra] - rise_cyc_a : -1, A_DLY); else n_pass++;
        n_checks++; if (done_cyc_a - rise_cyc_a != A_LEN - 1) $display("FAIL dflt_done_time: got %0d want %0d", done_cyc_a - rise_cyc_a, A_LEN - 1); else n_pass++;
        n_checks++; if (busy_cnt_a - bb0 != A_LEN) $display("FAIL dflt_busy_len: got %0d want %0d", busy_cnt_a - bb0, A_LEN); else n_pass++;
        n_checks++; if (bits_a.size() - nb != A_N * 16) $display("FAIL dflt_nbits: got %0d want %0d", bits_a.size() - nb, A_N * 16); else n_pass++;
        w0 = '0;
        for (int k = 0; k < 16; k++) if (nb + k < bits_a.size()) w0 = {w0[14:0], bits_a[nb + k]};
        n_checks++; if (w0 !== 16'h0100) $display("FAIL dflt_word0: got %h want 0100", w0); else n_pass++;
        e = 0;
        if (bits_a.size() < nb + A_N * 16) e = -1;
        else for (int k = 0; k < A_N * 16; k++) if (bits_a[nb + k] !== exp_bit_a(k)) e++;
        n_checks++; if (e != 0) $display("FAIL dflt_stream: %0d bit errors want 0", e); else n_pass++;
        n_checks++; if (le_cnt_a - ll0 != A_LW) $display("FAIL dflt_le_width: got %0d want %0d", le_cnt_a - ll0, A_LW); else n_pass++;
        n_checks++; if (done_cnt_a - dd0 != 1 || ovr_cnt_a != oo0) $display("FAIL dflt_pulses: done=%0d ovr=%0d want 1 0", done_cnt_a - dd0, ovr_cnt_a - oo0); else n_pass++;
        n_checks++; if (bad_a != gg0) $display("FAIL dflt_serial_rules: %0d violations want 0", bad_a - gg0); else n_pass++;
    endtask

    task automatic test_clkdiv1_wrap();
        logic [15:0] w0;
        fill_b();
        mem_b[B_BASE] = 16'hA5C3;
        snap_b();
        pulse_b();
        wait_done_b(B_LEN + 50, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL div1_timeout: frame_done not seen"); else n_pass++;
        w0 = '0;
        for (int k = 0; k < 16; k++) if (nb + k < bits_b.size()) w0 = {w0[14:0], bits_b[nb + k]};
        n_checks++; if (w0 !== 16'hA5C3) $display("FAIL div1_word0: got %h want a5c3", w0); else n_pass++;
        n_checks++; if (per2_b - p0 != B_N * 15) $display("FAIL div1_sclk_period: %0d 2-cycle periods want %0d", per2_b - p0, B_N * 15); else n_pass++;
        n_checks++; if (addr_b.size() < na + 5 || addr_b[na + 3] != 1023 || addr_b[na + 4] != 0) $display("FAIL div1_wrap: addr[3..4] not 1023,0 (nreads %0d)", addr_b.size() - na); else n_pass++;
        errs = 0;
        for (int i = 0; i < B_N; i++) if (na + i >= addr_b.size() || addr_b[na + i] != (B_BASE + i) % 1024) errs++;
        n_checks++; if (errs != 0) $display("FAIL div1_addr_order: %0d wrong addresses want 0", errs); else n_pass++;
        stream_errs_b();
        n_checks++; if (errs != 0) $display("FAIL div1_stream: %0d bit errors want 0", errs); else n_pass++;
        n_checks++; if (le_cnt_b - l0 != B_LW || bad_b != g0) $display("FAIL div1_latch: le=%0d viol=%0d want %0d 0", le_cnt_b - l0, bad_b - g0, B_LW); else n_pass++;
    endtask

    task automatic test_overrun();
        int c;
        fill_b();
        snap_b();
        ok = 1'b0; c = -1;
        @(negedge clk) fs_b = 1'b1;
        for (int i = 0; i < B_LEN + 100; i++) begin
            @(negedge clk);
            if (c >= 0 || busy_b) c++;
            if (c == 5)   fs_b = 1'b0;
            if (c == 100) fs_b = 1'b1;
            if (c == 101) fs_b = 1'b0;
            if (c == B_LEN - 1) begin
                n_checks++; if (done_b !== 1'b1) $display("FAIL ovr_done_cycle: frame_done=%b want 1", done_b); else n_pass++;
                fs_b = 1'b1;
            end
            if (c == B_LEN + 30) begin fs_b = 1'b0; ok = 1'b1; break; end
        end
        repeat (40) @(negedge clk);
        n_checks++; if (ok !== 1'b1 || busy_b !== 1'b0) $display("FAIL ovr_no_restart: reached=%b busy=%b want 1 0", ok, busy_b); else n_pass++;
        n_checks++; if (ovr_cnt_b - o0 != 2) $display("FAIL ovr_count: got %0d want 2", ovr_cnt_b - o0); else n_pass++;
        n_checks++; if (done_cnt_b - d0 != 1 || busy_cnt_b - b0 != B_LEN) $display("FAIL ovr_single_frame: done=%0d busy=%0d want 1 %0d", done_cnt_b - d0, busy_cnt_b - b0, B_LEN); else n_pass++;
        stream_errs_b();
        n_checks++; if (errs != 0 || bits_b.size() - nb != B_N * 16) $display("FAIL ovr_stream: errs=%0d nbits=%0d want 0 %0d", errs, bits_b.size() - nb, B_N * 16); else n_pass++;
    endtask

    task automatic test_held_high();
        fill_b();
        snap_b();
        @(negedge clk) fs_b = 1'b1;
        repeat (3 * B_LEN) @(negedge clk);
        fs_b = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++; if (done_cnt_b - d0 != 1 || busy_cnt_b - b0 != B_LEN) $display("FAIL held_one_frame: done=%0d busy=%0d want 1 %0d", done_cnt_b - d0, busy_cnt_b - b0, B_LEN); else n_pass++;
        n_checks++; if (ovr_cnt_b != o0) $display("FAIL held_overrun: got %0d want 0", ovr_cnt_b - o0); else n_pass++;
        stream_errs_b();
        n_checks++; if (errs != 0) $display("FAIL held_stream: %0d bit errors want 0", errs); else n_pass++;
    endtask

    task automatic test_reset_mid();
        fill_b();
        snap_b();
        pulse_b();
        ok = 1'b0;
        for (int i = 0; i < B_LEN; i++) begin
            @(negedge clk);
            if (addr_b.size() >= na + 6 && sclk_b) begin ok = 1'b1; break; end
        end
        fs_b = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (ok !== 1'b1 || sclk_b !== 1'b0) $display("FAIL rstmid_sclk: reached=%b sclk=%b want 1 0", ok, sclk_b); else n_pass++;
        n_checks++; if ({sdo_b, le_b, busy_b, bus_b.rd_en} !== 4'b0000) $display("FAIL rstmid_outputs: got %b want 0000", {sdo_b, le_b, busy_b, bus_b.rd_en}); else n_pass++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        n_checks++; if (busy_b !== 1'b0) $display("FAIL rstmid_held_level: busy=%b want 0", busy_b); else n_pass++;
        fs_b = 1'b0;
        repeat (2) @(negedge clk);
        snap_b();
        pulse_b();
        wait_done_b(B_LEN + 50, ok);
        n_checks++; if (ok !== 1'b1 || addr_b.size() <= na || addr_b[na] != B_BASE) $display("FAIL rstmid_restart: done=%b first addr=%0d want 1 %0d", ok, (addr_b.size() > na) ? addr_b[na] : -1, B_BASE); else n_pass++;
        stream_errs_b();
        n_checks++; if (errs != 0) $display("FAIL rstmid_stream: %0d bit errors want 0", errs); else n_pass++;
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 3; f++) begin
            fill_b();
            snap_b();
            repeat ($urandom_range(0, 4)) @(negedge clk);
            pulse_b();
            wait_done_b(B_LEN + 50, ok);
            stream_errs_b();
            n_checks++; if (ok !== 1'b1 || errs != 0 || done_cnt_b - d0 != 1) $display("FAIL b2b_frame%0d: done=%b errs=%0d ndone=%0d want 1 0 1", f, ok, errs, done_cnt_b - d0); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_frame_default();
        test_clkdiv1_wrap();
        test_overrun();
        test_held_high();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
